// File: rtl/hazard_unit_sb_if.sv
// Hazard unit bus: datapath pipeline-stage fields in, forward/stall/flush controls out.
interface hazard_unit_sb_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned NREG = 2 ** REG_AW;

  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic              rs1_use_d;
  logic              rs2_use_d;
  logic [REG_AW-1:0] rd_d;
  logic              reg_write_d;
  logic              mc_op_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic              load_e;
  logic              reg_write_e;
  logic              mc_issue_e;
  logic              pc_src_e;
  logic [REG_AW-1:0] rd_m;
  logic              reg_write_m;
  logic [REG_AW-1:0] rd_w;
  logic              reg_write_w;
  logic              mc_wb;
  logic [REG_AW-1:0] mc_wb_rd;

  logic [1:0]        forward_ae;
  logic [1:0]        forward_be;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  stall_cycles;

  // Datapath side
  modport master (
    output rs1_d, rs2_d, rs1_use_d, rs2_use_d, rd_d, reg_write_d, mc_op_d,
    output rs1_e, rs2_e, rd_e, load_e, reg_write_e, mc_issue_e, pc_src_e,
    output rd_m, reg_write_m, rd_w, reg_write_w, mc_wb, mc_wb_rd,
    input  forward_ae, forward_be, stall_f, stall_d, flush_d, flush_e,
    input  pending, stall_cycles
  );

  // Hazard unit side
  modport slave (
    input  rs1_d, rs2_d, rs1_use_d, rs2_use_d, rd_d, reg_write_d, mc_op_d,
    input  rs1_e, rs2_e, rd_e, load_e, reg_write_e, mc_issue_e, pc_src_e,
    input  rd_m, reg_write_m, rd_w, reg_write_w, mc_wb, mc_wb_rd,
    output forward_ae, forward_be, stall_f, stall_d, flush_d, flush_e,
    output pending, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_sb.sv
// Hazard controller: EX forwarding, load-use stall, branch flush, MC-op register scoreboard
// with outstanding-op limit, and a saturating stall-cycle counter.
module hazard_unit_sb #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_sb_if.slave hz
);
  localparam int unsigned NREG  = 2 ** REG_AW;
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned SUM_W = OUT_W + 1;

  logic [NREG-1:0]  r_pending;
  logic [OUT_W-1:0] r_outst;
  logic [CNT_W-1:0] r_stall_cycles;

  logic [NREG-1:0]  w_pending_nxt;
  logic [OUT_W-1:0] w_outst_nxt;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_lu;
  logic             w_sb;
  logic             w_set;
  logic             w_dec;
  logic             w_stall;

  // M-stage result beats W-stage result; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] rd_w
  );
    if (wr_m && rd_m != '0 && rd_m == rs) return 2'b01;
    if (wr_w && rd_w != '0 && rd_w == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Hazard detection and next scoreboard state
  always_comb begin
    w_fwd_a = fwd_sel(hz.rs1_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
    w_fwd_b = fwd_sel(hz.rs2_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);

    w_lu = hz.load_e && (hz.rd_e != '0) &&
           ((hz.rs1_use_d && hz.rd_e == hz.rs1_d) || (hz.rs2_use_d && hz.rd_e == hz.rs2_d));

    w_sb = (hz.rs1_use_d && r_pending[hz.rs1_d]) ||
           (hz.rs2_use_d && r_pending[hz.rs2_d]) ||
           (hz.reg_write_d && (hz.rd_d != '0) && r_pending[hz.rd_d]) ||
           (hz.mc_op_d && ((SUM_W'(r_outst) + SUM_W'(hz.mc_issue_e)) >= SUM_W'(MAX_OUTST)));

    // A taken branch squashes decode, so its hazards no longer matter
    w_stall = (w_lu || w_sb) && !hz.pc_src_e && !rst;

    w_set = hz.mc_issue_e && (hz.rd_e != '0);
    w_dec = hz.mc_wb && r_pending[hz.mc_wb_rd];

    // Clear first so a same-cycle set on the same register wins
    w_pending_nxt = r_pending;
    if (hz.mc_wb) w_pending_nxt[hz.mc_wb_rd] = 1'b0;
    if (w_set)    w_pending_nxt[hz.rd_e]     = 1'b1;
    w_pending_nxt[0] = 1'b0;

    w_outst_nxt = r_outst;
    if (w_set && !w_dec && r_outst != OUT_W'(MAX_OUTST)) begin
      w_outst_nxt = r_outst + OUT_W'(1);
    end else if (w_dec && !w_set && r_outst != '0) begin
      w_outst_nxt = r_outst - OUT_W'(1);
    end
  end

  // Scoreboard, outstanding count and stall counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending      <= '0;
      r_outst        <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_outst   <= w_outst_nxt;
      if (w_stall && r_stall_cycles != '1) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign hz.forward_ae   = rst ? 2'b00 : w_fwd_a;
  assign hz.forward_be   = rst ? 2'b00 : w_fwd_b;
  assign hz.stall_f      = w_stall;
  assign hz.stall_d      = w_stall;
  assign hz.flush_e      = w_stall || (hz.pc_src_e && !rst);
  assign hz.flush_d      = hz.pc_src_e && !rst;
  assign hz.pending      = r_pending;
  assign hz.stall_cycles = r_stall_cycles;

  // Issuing with the MC unit already full would lose an op
  a_no_overissue: assert property (@(posedge clk) disable iff (rst)
    !(w_set && r_outst == OUT_W'(MAX_OUTST)));

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb with a scoreboard reference model.
module tb_hazard_unit_sb;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NREG      = 32;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit m_pend[NREG];
  int m_outst;
  int m_cnt;

  hazard_unit_sb_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz();

  hazard_unit_sb #(.REG_AW(REG_AW), .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hz.reg_write_m && hz.rd_m != 0 && hz.rd_m == rs) return 2'b01;
    if (hz.reg_write_w && hz.rd_w != 0 && hz.rd_w == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit lu, sb;
    lu = hz.load_e && hz.rd_e != 0 &&
         ((hz.rs1_use_d && hz.rd_e == hz.rs1_d) || (hz.rs2_use_d && hz.rd_e == hz.rs2_d));
    sb = (hz.rs1_use_d && m_pend[hz.rs1_d]) || (hz.rs2_use_d && m_pend[hz.rs2_d]) ||
         (hz.reg_write_d && hz.rd_d != 0 && m_pend[hz.rd_d]) ||
         (hz.mc_op_d && (m_outst + int'(hz.mc_issue_e)) >= int'(MAX_OUTST));
    return (lu || sb) && !hz.pc_src_e;
  endfunction

  function automatic logic [NREG-1:0] m_pvec();
    logic [NREG-1:0] v;
    for (int i = 0; i < int'(NREG); i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NREG); i++) m_pend[i] = 1'b0;
    m_outst = 0;
    m_cnt   = 0;
  endtask

  // Advance the model with the inputs now applied, then clock the DUT
  task automatic tick();
    bit s, inc, dec;
    if (rst) begin
      m_reset();
    end else begin
      s   = m_stall();
      inc = hz.mc_issue_e && hz.rd_e != 0;
      dec = hz.mc_wb && m_pend[hz.mc_wb_rd];
      if (hz.mc_wb) m_pend[hz.mc_wb_rd] = 1'b0;
      if (inc) m_pend[hz.rd_e] = 1'b1;
      m_pend[0] = 1'b0;
      if (inc && !dec && m_outst < int'(MAX_OUTST)) m_outst++;
      else if (dec && !inc && m_outst > 0) m_outst--;
      if (s && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_use_d = 0; hz.rs2_use_d = 0;
    hz.rd_d = '0; hz.reg_write_d = 0; hz.mc_op_d = 0;
    hz.rs1_e = '0; hz.rs2_e = '0; hz.rd_e = '0; hz.load_e = 0; hz.reg_write_e = 0;
    hz.mc_issue_e = 0; hz.pc_src_e = 0;
    hz.rd_m = '0; hz.reg_write_m = 0; hz.rd_w = '0; hz.reg_write_w = 0;
    hz.mc_wb = 0; hz.mc_wb_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_reset();
    hz.rd_m = 5'd5; hz.reg_write_m = 1; hz.rs1_e = 5'd5;
    hz.load_e = 1; hz.rd_e = 5'd7; hz.rs1_d = 5'd7; hz.rs1_use_d = 1; hz.pc_src_e = 1;
    #1;
    n_checks++;
    if (hz.forward_ae !== 2'b00) begin n_fail++; $display("FAIL rst_fwd: got %b exp 00", hz.forward_ae); end
    n_checks++;
    if (hz.stall_d !== 1'b0 || hz.stall_f !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall: got %b%b exp 00", hz.stall_f, hz.stall_d);
    end
    n_checks++;
    if (hz.flush_d !== 1'b0 || hz.flush_e !== 1'b0) begin
      n_fail++; $display("FAIL rst_flush: got %b%b exp 00", hz.flush_d, hz.flush_e);
    end
    tick();
    n_checks++;
    if (hz.pending !== '0 || hz.stall_cycles !== '0) begin
      n_fail++; $display("FAIL rst_state: got %h/%h exp 0/0", hz.pending, hz.stall_cycles);
    end
    clear_inputs();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hz.rd_m = 5'd5; hz.rd_w = 5'd5; hz.rs1_e = 5'd5; hz.reg_write_m = 1; hz.reg_write_w = 1;
    #1;
    n_checks++;
    if (hz.forward_ae !== 2'b01) begin n_fail++; $display("FAIL fwd_m: got %b exp 01", hz.forward_ae); end
    hz.reg_write_m = 0; hz.rs2_e = 5'd5;
    #1;
    n_checks++;
    if (hz.forward_ae !== 2'b10) begin n_fail++; $display("FAIL fwd_w: got %b exp 10", hz.forward_ae); end
    n_checks++;
    if (hz.forward_be !== 2'b10) begin n_fail++; $display("FAIL fwd_w_b: got %b exp 10", hz.forward_be); end
    hz.rs1_e = 5'd0; hz.rd_m = 5'd0; hz.rd_w = 5'd0; hz.reg_write_m = 1;
    #1;
    n_checks++;
    if (hz.forward_ae !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b exp 00", hz.forward_ae); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.load_e = 1; hz.rd_e = 5'd7; hz.rs2_d = 5'd7; hz.rs2_use_d = 1;
    #1;
    n_checks++;
    if ({hz.stall_f, hz.stall_d, hz.flush_e, hz.flush_d} !== 4'b1110) begin
      n_fail++; $display("FAIL lu_ctrl: got %b%b%b%b exp 1110", hz.stall_f, hz.stall_d, hz.flush_e, hz.flush_d);
    end
    tick();
    n_checks++;
    if (hz.stall_cycles !== CNT_W'(m_cnt) || m_cnt != 1) begin
      n_fail++; $display("FAIL lu_cnt: got %0d exp 1", hz.stall_cycles);
    end
    hz.rs2_use_d = 0;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b0) begin n_fail++; $display("FAIL lu_nouse: got %b exp 0", hz.stall_d); end
    clear_inputs();
  endtask

  task automatic test_branch_override();
    clear_inputs();
    hz.load_e = 1; hz.rd_e = 5'd7; hz.rs2_d = 5'd7; hz.rs2_use_d = 1; hz.pc_src_e = 1;
    #1;
    n_checks++;
    if ({hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e} !== 4'b0011) begin
      n_fail++; $display("FAIL br_ctrl: got %b%b%b%b exp 0011", hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e);
    end
    tick();
    n_checks++;
    if (hz.stall_cycles !== CNT_W'(m_cnt)) begin
      n_fail++; $display("FAIL br_cnt: got %0d exp %0d", hz.stall_cycles, m_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_scoreboard_raw();
    clear_inputs();
    hz.mc_issue_e = 1; hz.rd_e = 5'd9;
    tick();
    clear_inputs();
    hz.rs1_d = 5'd9; hz.rs1_use_d = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (hz.stall_d !== 1'b1 || hz.pending[9] !== 1'b1) begin
        n_fail++; $display("FAIL raw_wait%0d: got stall=%b pend9=%b exp 1/1", i, hz.stall_d, hz.pending[9]);
      end
      tick();
    end
    hz.mc_wb = 1; hz.mc_wb_rd = 5'd9;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b1) begin n_fail++; $display("FAIL raw_wbcycle: got %b exp 1", hz.stall_d); end
    tick();
    hz.mc_wb = 0;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b0 || hz.pending[9] !== 1'b0) begin
      n_fail++; $display("FAIL raw_release: got stall=%b pend9=%b exp 0/0", hz.stall_d, hz.pending[9]);
    end
    clear_inputs();
  endtask

  task automatic test_structural();
    clear_inputs();
    hz.mc_issue_e = 1; hz.rd_e = 5'd3; tick();
    hz.rd_e = 5'd4; tick();
    clear_inputs();
    hz.mc_op_d = 1;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b1) begin n_fail++; $display("FAIL st_full: got %b exp 1", hz.stall_d); end
    hz.mc_wb = 1; hz.mc_wb_rd = 5'd3;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b1) begin n_fail++; $display("FAIL st_wbcycle: got %b exp 1", hz.stall_d); end
    tick();
    hz.mc_wb = 0;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b0) begin n_fail++; $display("FAIL st_release: got %b exp 0", hz.stall_d); end
    hz.mc_op_d = 0; hz.mc_wb = 1; hz.mc_wb_rd = 5'd4; tick();
    clear_inputs();
    hz.mc_issue_e = 1; hz.rd_e = 5'd6; tick();
    hz.mc_wb = 1; hz.mc_wb_rd = 5'd6; tick();
    clear_inputs();
    #1;
    n_checks++;
    if (hz.pending !== m_pvec() || hz.pending[6] !== 1'b1) begin
      n_fail++; $display("FAIL st_setwins: got %h exp %h", hz.pending, m_pvec());
    end
    hz.mc_op_d = 1;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b0) begin n_fail++; $display("FAIL st_outst1: got %b exp 0", hz.stall_d); end
    hz.mc_issue_e = 1; hz.rd_e = 5'd7;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b1) begin n_fail++; $display("FAIL st_issue_sum: got %b exp 1", hz.stall_d); end
    clear_inputs();
    hz.reg_write_d = 1; hz.rd_d = 5'd6;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b1) begin n_fail++; $display("FAIL st_waw: got %b exp 1", hz.stall_d); end
    clear_inputs();
    hz.mc_wb = 1; hz.mc_wb_rd = 5'd6; tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    hz.mc_issue_e = 1; hz.rd_e = 5'd3; tick();
    clear_inputs();
    hz.rs1_d = 5'd3; hz.rs1_use_d = 1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (hz.stall_cycles !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %h exp f", hz.stall_cycles); end
    tick();
    n_checks++;
    if (hz.stall_cycles !== 4'hF || hz.pending[3] !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold: got %h pend3=%b exp f/1", hz.stall_cycles, hz.pending[3]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (hz.pending !== '0 || hz.stall_cycles !== '0 || hz.stall_d !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: got %h/%h/%b exp 0/0/0", hz.pending, hz.stall_cycles, hz.stall_d);
    end
    m_reset();
    #2;
    rst = 1'b0;
    hz.mc_op_d = 1; hz.mc_issue_e = 1; hz.rd_e = 5'd0;
    #1;
    n_checks++;
    if (hz.stall_d !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got %b exp 0", hz.stall_d); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [4:0] cand;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) begin
        rst = 1'b1; #1; m_reset(); rst = 1'b0;
      end
      hz.rs1_d = 5'($urandom_range(0, 7)); hz.rs2_d = 5'($urandom_range(0, 7));
      hz.rs1_use_d = 1'($urandom_range(0, 1)); hz.rs2_use_d = 1'($urandom_range(0, 1));
      hz.rd_d = 5'($urandom_range(0, 7)); hz.reg_write_d = 1'($urandom_range(0, 1));
      hz.mc_op_d = ($urandom_range(0, 3) == 0);
      hz.rs1_e = 5'($urandom_range(0, 7)); hz.rs2_e = 5'($urandom_range(0, 7));
      hz.load_e = ($urandom_range(0, 3) == 0); hz.reg_write_e = 1'($urandom_range(0, 1));
      hz.pc_src_e = ($urandom_range(0, 7) == 0);
      hz.rd_m = 5'($urandom_range(0, 7)); hz.reg_write_m = 1'($urandom_range(0, 1));
      hz.rd_w = 5'($urandom_range(0, 7)); hz.reg_write_w = 1'($urandom_range(0, 1));
      cand = 5'($urandom_range(0, 7));
      hz.rd_e = cand;
      hz.mc_issue_e = ($urandom_range(0, 2) == 0) && m_outst < int'(MAX_OUTST) &&
                      cand != 0 && !m_pend[cand];
      hz.mc_wb = ($urandom_range(0, 2) == 0);
      hz.mc_wb_rd = 5'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (hz.forward_ae !== m_fwd(hz.rs1_e) || hz.forward_be !== m_fwd(hz.rs2_e)) begin
        n_fail++; $display("FAIL rnd_fwd[%0d]: got %b/%b exp %b/%b", i, hz.forward_ae, hz.forward_be,
                           m_fwd(hz.rs1_e), m_fwd(hz.rs2_e));
      end
      n_checks++;
      if (hz.stall_d !== m_stall() || hz.stall_f !== m_stall() ||
          hz.flush_e !== (m_stall() || hz.pc_src_e) || hz.flush_d !== hz.pc_src_e) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: got sf=%b sd=%b fd=%b fe=%b exp stall=%b br=%b", i,
                           hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e, m_stall(), hz.pc_src_e);
      end
      n_checks++;
      if (hz.pending !== m_pvec() || hz.stall_cycles !== CNT_W'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got %h/%0d exp %h/%0d", i, hz.pending,
                           hz.stall_cycles, m_pvec(), m_cnt);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_override();
    test_scoreboard_raw();
    test_structural();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
